// File: rtl/gray2rgb_ser_if.sv
// Handshake bundle for gray2rgb_ser: gray pixel in, serial R/G/B channel beats out.
// The design attaches through the slave modport; the driving side uses master.
interface gray2rgb_ser_if #(
  parameter int WIDTH_P = 8
) ();

  logic               valid_i;
  logic               ready_o;
  logic [WIDTH_P-1:0] gray_i;
  logic               valid_o;
  logic               ready_i;
  logic [WIDTH_P-1:0] data_o;
  logic [1:0]         chan_o;
  logic               last_o;

  modport slave (
    input  valid_i,
    input  gray_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output chan_o,
    output last_o
  );

  modport master (
    output valid_i,
    output gray_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  chan_o,
    input  last_o
  );

endinterface

// File: rtl/gray2rgb_ser.sv
// Gray-to-RGB serializer: one gray pixel in, three channel beats (R, G, B) out.
// Define GRAY2RGB_HEATMAP_EN for heat-map pseudo-colour instead of replicated gray.
module gray2rgb_ser #(
  parameter int WIDTH_P = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  gray2rgb_ser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_R = 2'd1,
    SEND_G = 2'd2,
    SEND_B = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH_P-1:0] r;
    logic [WIDTH_P-1:0] g;
    logic [WIDTH_P-1:0] b;
  } rgb_t;

`ifdef GRAY2RGB_HEATMAP_EN
  localparam logic [WIDTH_P-1:0] HALF_C = {1'b1, {(WIDTH_P-1){1'b0}}};
  localparam logic [WIDTH_P-1:0] MAX_C  = {WIDTH_P{1'b1}};
  localparam logic [WIDTH_P-1:0] ONE_C  = {{(WIDTH_P-1){1'b0}}, 1'b1};
`endif

  // Every subtraction below stays in range because of the half-range split.
  function automatic rgb_t expand(input logic [WIDTH_P-1:0] gray);
    rgb_t               c;
    logic [WIDTH_P-1:0] t;
    c = {(3*WIDTH_P){1'b0}};
    t = {WIDTH_P{1'b0}};
`ifdef GRAY2RGB_HEATMAP_EN
    if (gray >= HALF_C) begin
      t   = gray - HALF_C;
      c.r = {t[WIDTH_P-2:0], 1'b0};
      t   = MAX_C - gray;
      c.g = {t[WIDTH_P-2:0], 1'b0};
      c.b = {WIDTH_P{1'b0}};
    end else begin
      c.r = {WIDTH_P{1'b0}};
      c.g = {gray[WIDTH_P-2:0], 1'b0};
      t   = HALF_C - ONE_C - gray;
      c.b = {t[WIDTH_P-2:0], 1'b0};
    end
`else
    c.r = gray;
    c.g = gray;
    c.b = gray;
`endif
    return c;
  endfunction

  state_t             state_r;
  logic [WIDTH_P-1:0] r_hold_r;
  logic [WIDTH_P-1:0] g_hold_r;
  logic [WIDTH_P-1:0] b_hold_r;
  logic               valid_r;
  logic [1:0]         chan_r;
  logic               last_r;

  logic               ready_s;
  logic               in_fire_s;
  logic               out_fire_s;
  logic [WIDTH_P-1:0] data_s;
  rgb_t               pix_s;

  assign pix_s      = expand(bus.gray_i);
  assign in_fire_s  = bus.valid_i && ready_s;
  assign out_fire_s = valid_r && bus.ready_i;

  // Input ready: idle, or the final beat is leaving this cycle.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == IDLE) begin
      ready_s = 1'b1;
    end else if (state_r == SEND_B) begin
      ready_s = bus.ready_i;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Beat data comes straight from the holding registers selected by state.
  always_comb begin
    data_s = {WIDTH_P{1'b0}};
    case (state_r)
      SEND_R:  data_s = r_hold_r;
      SEND_G:  data_s = g_hold_r;
      SEND_B:  data_s = b_hold_r;
      default: data_s = {WIDTH_P{1'b0}};
    endcase
  end

  // Serializer FSM with its registered handshake outputs and pixel capture.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= IDLE;
      r_hold_r <= {WIDTH_P{1'b0}};
      g_hold_r <= {WIDTH_P{1'b0}};
      b_hold_r <= {WIDTH_P{1'b0}};
      valid_r  <= 1'b0;
      chan_r   <= 2'd0;
      last_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_fire_s) begin
            r_hold_r <= pix_s.r;
            g_hold_r <= pix_s.g;
            b_hold_r <= pix_s.b;
            state_r  <= SEND_R;
            valid_r  <= 1'b1;
            chan_r   <= 2'd0;
            last_r   <= 1'b0;
          end
        end
        SEND_R: begin
          if (out_fire_s) begin
            state_r <= SEND_G;
            chan_r  <= 2'd1;
          end
        end
        SEND_G: begin
          if (out_fire_s) begin
            state_r <= SEND_B;
            chan_r  <= 2'd2;
            last_r  <= 1'b1;
          end
        end
        SEND_B: begin
          // A pixel taken alongside the last beat starts with no bubble.
          if (out_fire_s) begin
            if (in_fire_s) begin
              r_hold_r <= pix_s.r;
              g_hold_r <= pix_s.g;
              b_hold_r <= pix_s.b;
              state_r  <= SEND_R;
              valid_r  <= 1'b1;
              chan_r   <= 2'd0;
              last_r   <= 1'b0;
            end else begin
              state_r <= IDLE;
              valid_r <= 1'b0;
              chan_r  <= 2'd0;
              last_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          chan_r  <= 2'd0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_s;
  assign bus.valid_o = valid_r;
  assign bus.data_o  = data_s;
  assign bus.chan_o  = chan_r;
  assign bus.last_o  = last_r;

endmodule
